xp10_decomp_fe_tlv_split: RTL and testbench
===========================================

XP10_DECOMP_FE_TLV_SPLIT -- requirements
Module: xp10_decomp_fe_tlv_split

Interface
REQ-001 SHALL have parameter USR_TYPE_MASK, default 32'h0000_000C: bit t set routes TLV type t (0..31) to user port; types >=32 always pass-through.
REQ-002 SHALL have parameter SKID_DEPTH, default 2: input skid-buffer entries (fixed 2; other values unsupported).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 axi_ib_tvalid  in  1  ingress word valid.
REQ-007 axi_ib_tready  out  1  ingress ready, registered.
REQ-008 axi_ib_tdata  in  64  ingress word; on SOT word [7:0]=type, [31:16]=TLV length in words incl. header.
REQ-009 axi_ib_tctl  in  3  [0]=SOT, [1]=EOT, [2]=frame last.
REQ-010 pt_ib_wr / pt_ib_data / pt_ib_ctl  out  1/64/3  pass-through FIFO write port, ctl as tctl.
REQ-011 pt_ib_afull  in  1  pass-through FIFO almost-full (>=2 free when low).
REQ-012 usr_valid / usr_data / usr_ctl / usr_type  out  1/64/3/8  user-side TLV word stream.
REQ-013 usr_ready  in  1  user-side accept.
REQ-014 err_pulse  out  1  one-cycle pulse per protocol or length error.
REQ-015 err_cnt  out  16  saturating error count.

Function
REQ-016 SHALL accept an ingress word when tvalid && tready; tready = skid buffer not full.
REQ-017 SHALL hold words in a 2-entry skid buffer; tready deasserts the cycle after buffer reaches 2 entries.
REQ-018 SHALL use FSM states IDLE, PT, USR, DROP; reset state IDLE.
REQ-019 IDLE + SOT word: type in USR_TYPE_MASK -> USR, else -> PT; latch type and length; word counter = 1.
REQ-020 IDLE + non-SOT word: discard, err_pulse, -> DROP.
REQ-021 DROP: discard words until a word with SOT, then route as REQ-019 in same cycle.
REQ-022 PT: pop head word only when !pt_ib_afull; pt_ib_wr pulses with word.
REQ-023 USR: usr_valid held with stable data until usr_ready; word pops on valid && ready.
REQ-024 usr_type SHALL equal latched header type for every word of the TLV.
REQ-025 EOT word SHALL return FSM to IDLE after forwarding; SOT+EOT single-word TLV forwarded and returns to IDLE.
REQ-026 SOT arriving in PT/USR SHALL: forward it with ctl[1] forced 1 (terminating current TLV), err_pulse, -> IDLE, word not reprocessed as new header.
REQ-027 On EOT, word counter != latched length SHALL raise err_pulse; word still forwarded.
REQ-028 Word counter 16-bit, saturates at 16'hFFFF; length 0 always mismatches.
REQ-029 Latency: ingress accept to pt_ib_wr/usr_valid = 2 cycles minimum with no backpressure; throughput 1 word/cycle.
REQ-030 Simultaneous errors in one cycle SHALL count once; err_cnt saturates at 16'hFFFF.
REQ-031 Word order SHALL be preserved; no word duplicated or dropped except in IDLE/DROP discards.

Reset
REQ-032 All outputs 0 during reset except axi_ib_tready 0; tready rises first cycle after rst deasserts.
REQ-033 Reset mid-TLV SHALL discard buffered words and emit no EOT; skid buffer, counters, FSM cleared.

Configuration
REQ-034 Macro XP10_DECOMP_FE_TLV_ERR_CNT_EN: defined -> err_cnt counter implemented; undefined -> err_cnt tied 16'h0, err_pulse still functional.

Structure
REQ-035 Shared package SHALL hold FSM state enum, tctl bit indices, header field offsets, default USR_TYPE_MASK.
REQ-036 Skid buffer SHALL be sub-module xp10_decomp_fe_skid (2-entry, valid/ready both sides).

Verification
REQ-037 Type 0x02 TLV, len 3, SOT/mid/EOT, no backpressure -> 3 usr words, usr_type=0x02, first at +2 cycles, err_cnt=0.
REQ-038 Type 0x05 TLV len 4, pt_ib_afull high 5 cycles mid-TLV -> no pt_ib_wr while afull, 4 writes total, order intact, tready drops.
REQ-039 Non-SOT word in IDLE then type 0x03 TLV len 2 -> first word discarded, err_cnt=1, 2 usr words.
REQ-040 Type 0x02 header len 5, EOT on word 3 -> 3 words forwarded, err_pulse once, err_cnt=1.
REQ-041 rst asserted after 2nd word of 4-word TLV -> outputs 0, next SOT TLV forwarded cleanly, no stray EOT.
REQ-042 Build without XP10_DECOMP_FE_TLV_ERR_CNT_EN, run REQ-039 -> err_pulse seen, err_cnt=0.

Source files
------------

// File: rtl/xp10_decomp_fe_tlv_split_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xp10_decomp_fe_tlv_split_pkg
// Description : Shared types and constants for the XP10 decompressor front-end
//               TLV splitter: FSM state encoding, tctl bit positions, header
//               field offsets and the default user-type routing mask.
// Revision    : 1.0 - initial release
// ============================================================================
package xp10_decomp_fe_tlv_split_pkg;

    // Splitter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PT   = 2'd1,
        USR  = 2'd2,
        DROP = 2'd3
    } tlv_state_t;

    // tctl bit positions
    localparam int c_ctl_sot  = 0;
    localparam int c_ctl_eot  = 1;
    localparam int c_ctl_last = 2;

    // Header word field positions
    localparam int c_hdr_type_lsb = 0;
    localparam int c_hdr_type_msb = 7;
    localparam int c_hdr_len_lsb  = 16;
    localparam int c_hdr_len_msb  = 31;

    // Types 2 and 3 go to the user port by default
    localparam logic [31:0] c_usr_type_mask_dflt = 32'h0000_000C;

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    // Increment that sticks at all-ones
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == c_cnt_max) ? value : value + 16'd1;
    endfunction

endpackage : xp10_decomp_fe_tlv_split_pkg

`default_nettype wire

// File: rtl/xp10_decomp_fe_skid.sv
`default_nettype none
// ============================================================================
// Module      : xp10_decomp_fe_skid
// Description : Two-entry skid buffer with valid/ready on both sides. The
//               input ready is registered and drops the cycle after the
//               buffer holds two entries; it is low while in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module xp10_decomp_fe_skid #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 67
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] c_depth = DEPTH[1:0];

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_ready;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    assign w_push    = in_valid && r_ready;
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign in_ready  = r_ready;
    assign out_data  = r_mem[r_rd_ptr];

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Pointers, occupancy and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != c_depth);
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // Storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule : xp10_decomp_fe_skid

`default_nettype wire

// File: rtl/xp10_decomp_fe_tlv_split.sv
`default_nettype none
// ============================================================================
// Module      : xp10_decomp_fe_tlv_split
// Description : Splits the ingress TLV word stream into a pass-through FIFO
//               write port and a user-side valid/ready stream, routed on the
//               TLV type of each header. Detects framing and length errors.
//               Optional macro XP10_DECOMP_FE_TLV_ERR_CNT_EN enables the
//               saturating error counter (err_cnt is zero otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module xp10_decomp_fe_tlv_split
    import xp10_decomp_fe_tlv_split_pkg::*;
#(
    parameter logic [31:0] USR_TYPE_MASK = c_usr_type_mask_dflt,
    parameter int          SKID_DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_ib_tvalid,
    output logic        axi_ib_tready,
    input  logic [63:0] axi_ib_tdata,
    input  logic [2:0]  axi_ib_tctl,
    output logic        pt_ib_wr,
    output logic [63:0] pt_ib_data,
    output logic [2:0]  pt_ib_ctl,
    input  logic        pt_ib_afull,
    output logic        usr_valid,
    output logic [63:0] usr_data,
    output logic [2:0]  usr_ctl,
    output logic [7:0]  usr_type,
    input  logic        usr_ready,
    output logic        err_pulse,
    output logic [15:0] err_cnt
);

    // Skid buffer head
    logic        w_head_valid;
    logic [66:0] w_head_word;
    logic [63:0] w_head_data;
    logic [2:0]  w_head_ctl;
    logic        w_pop;

    // FSM and TLV context
    tlv_state_t  r_state;
    tlv_state_t  w_state_nxt;
    logic [7:0]  r_type;
    logic [7:0]  w_type_nxt;
    logic [15:0] r_len;
    logic [15:0] w_len_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;

    // Header decode of the head word
    logic [7:0]  w_hdr_type;
    logic [15:0] w_hdr_len;
    logic        w_hdr_usr;
    logic        w_hdr_dest_ok;
    logic        w_body_dest_ok;
    logic        w_usr_space;

    // Forwarding controls
    logic        w_pt_fwd;
    logic        w_usr_fwd;
    logic [2:0]  w_fwd_ctl;
    logic [7:0]  w_fwd_type;
    logic        w_err;

    // Output registers
    logic        r_pt_wr;
    logic [63:0] r_pt_data;
    logic [2:0]  r_pt_ctl;
    logic        r_usr_valid;
    logic [63:0] r_usr_data;
    logic [2:0]  r_usr_ctl;
    logic [7:0]  r_usr_type;
    logic        r_err_pulse;

    xp10_decomp_fe_skid #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (67)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (axi_ib_tvalid),
        .in_ready  (axi_ib_tready),
        .in_data   ({axi_ib_tctl, axi_ib_tdata}),
        .out_valid (w_head_valid),
        .out_ready (w_pop),
        .out_data  (w_head_word)
    );

    assign w_head_data = w_head_word[63:0];
    assign w_head_ctl  = w_head_word[66:64];

    // Only types below 32 can be steered to the user port
    assign w_hdr_type  = w_head_data[c_hdr_type_msb:c_hdr_type_lsb];
    assign w_hdr_len   = w_head_data[c_hdr_len_msb:c_hdr_len_lsb];
    assign w_hdr_usr   = (w_hdr_type[7:5] == 3'd0) && USR_TYPE_MASK[w_hdr_type[4:0]];

    // User output register can take a word if empty or draining this cycle
    assign w_usr_space    = !r_usr_valid || usr_ready;
    assign w_hdr_dest_ok  = w_hdr_usr ? w_usr_space : !pt_ib_afull;
    assign w_body_dest_ok = (r_state == USR) ? w_usr_space : !pt_ib_afull;

    // Next-state, pop and forwarding decisions for the skid head word
    always_comb begin
        w_state_nxt = r_state;
        w_type_nxt  = r_type;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_err       = 1'b0;
        w_pt_fwd    = 1'b0;
        w_usr_fwd   = 1'b0;
        w_fwd_ctl   = w_head_ctl;
        w_fwd_type  = r_type;
        case (r_state)
            IDLE, DROP: begin
                if (w_head_valid) begin
                    if (w_head_ctl[c_ctl_sot]) begin
                        // New header: wait until its destination has room
                        if (w_hdr_dest_ok) begin
                            w_pop      = 1'b1;
                            w_pt_fwd   = !w_hdr_usr;
                            w_usr_fwd  = w_hdr_usr;
                            w_fwd_type = w_hdr_type;
                            w_type_nxt = w_hdr_type;
                            w_len_nxt  = w_hdr_len;
                            w_cnt_nxt  = 16'd1;
                            if (w_head_ctl[c_ctl_eot]) begin
                                w_err       = (w_hdr_len != 16'd1);
                                w_state_nxt = IDLE;
                            end else begin
                                w_state_nxt = w_hdr_usr ? USR : PT;
                            end
                        end
                    end else begin
                        // Orphan body word: drop it, flag only the first one
                        w_pop       = 1'b1;
                        w_err       = (r_state == IDLE);
                        w_state_nxt = DROP;
                    end
                end
            end
            PT, USR: begin
                if (w_head_valid && w_body_dest_ok) begin
                    w_pop     = 1'b1;
                    w_pt_fwd  = (r_state == PT);
                    w_usr_fwd = (r_state == USR);
                    if (w_head_ctl[c_ctl_sot]) begin
                        // Premature header closes the current TLV instead
                        w_fwd_ctl[c_ctl_eot] = 1'b1;
                        w_err                = 1'b1;
                        w_state_nxt          = IDLE;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                        if (w_head_ctl[c_ctl_eot]) begin
                            w_err       = (w_cnt_nxt != r_len);
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state and latched TLV context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_type  <= 8'd0;
            r_len   <= 16'd0;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_type  <= w_type_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pass-through write port: one-cycle write strobe with the word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pt_wr   <= 1'b0;
            r_pt_data <= 64'd0;
            r_pt_ctl  <= 3'd0;
        end else begin
            r_pt_wr <= w_pt_fwd;
            if (w_pt_fwd) begin
                r_pt_data <= w_head_data;
                r_pt_ctl  <= w_fwd_ctl;
            end
        end
    end

    // User output register: holds the word until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_usr_valid <= 1'b0;
            r_usr_data  <= 64'd0;
            r_usr_ctl   <= 3'd0;
            r_usr_type  <= 8'd0;
        end else if (w_usr_fwd) begin
            r_usr_valid <= 1'b1;
            r_usr_data  <= w_head_data;
            r_usr_ctl   <= w_fwd_ctl;
            r_usr_type  <= w_fwd_type;
        end else if (usr_ready) begin
            r_usr_valid <= 1'b0;
        end
    end

    // At most one error is reported per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_err;
        end
    end

`ifdef XP10_DECOMP_FE_TLV_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Saturating error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 16'd0;
        end else if (w_err) begin
            r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'h0000;
`endif

    assign pt_ib_wr   = r_pt_wr;
    assign pt_ib_data = r_pt_data;
    assign pt_ib_ctl  = r_pt_ctl;
    assign usr_valid  = r_usr_valid;
    assign usr_data   = r_usr_data;
    assign usr_ctl    = r_usr_ctl;
    assign usr_type   = r_usr_type;
    assign err_pulse  = r_err_pulse;

endmodule : xp10_decomp_fe_tlv_split

`default_nettype wire

// File: tb/tb_xp10_decomp_fe_tlv_split.sv
`default_nettype none
// ============================================================================
// Module      : tb_xp10_decomp_fe_tlv_split
// Description : Self-checking bench for xp10_decomp_fe_tlv_split. A word-level
//               reference model turns every accepted ingress word into the
//               expected pass-through / user output streams and error count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xp10_decomp_fe_tlv_split;

    localparam logic [31:0] MASK   = 32'h0000_000C;
    localparam int          PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        axi_ib_tvalid;
    logic        axi_ib_tready;
    logic [63:0] axi_ib_tdata;
    logic [2:0]  axi_ib_tctl;
    logic        pt_ib_wr;
    logic [63:0] pt_ib_data;
    logic [2:0]  pt_ib_ctl;
    logic        pt_ib_afull;
    logic        usr_valid;
    logic [63:0] usr_data;
    logic [2:0]  usr_ctl;
    logic [7:0]  usr_type;
    logic        usr_ready;
    logic        err_pulse;
    logic [15:0] err_cnt;

    xp10_decomp_fe_tlv_split #(
        .USR_TYPE_MASK (MASK),
        .SKID_DEPTH    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .axi_ib_tvalid (axi_ib_tvalid),
        .axi_ib_tready (axi_ib_tready),
        .axi_ib_tdata  (axi_ib_tdata),
        .axi_ib_tctl   (axi_ib_tctl),
        .pt_ib_wr      (pt_ib_wr),
        .pt_ib_data    (pt_ib_data),
        .pt_ib_ctl     (pt_ib_ctl),
        .pt_ib_afull   (pt_ib_afull),
        .usr_valid     (usr_valid),
        .usr_data      (usr_data),
        .usr_ctl       (usr_ctl),
        .usr_type      (usr_type),
        .usr_ready     (usr_ready),
        .err_pulse     (err_pulse),
        .err_cnt       (err_cnt)
    );

    initial forever #(PERIOD/2) clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_mode = 0;   // 0 idle, 1 pass-through, 2 user, 3 dropping
    logic [7:0]  m_type = 8'd0;
    int          m_len  = 0;
    int          m_cnt  = 0;
    int          m_err  = 0;
    logic [66:0] exp_pt[$];
    logic [74:0] exp_usr[$];

    // Observation
    int  pulses    = 0;
    int  pt_wr_cnt = 0;
    int  usr_cnt   = 0;
    bit  tready_low_seen = 1'b0;
    bit  edge_afull = 1'b0;
    bit  rnd_bp = 1'b0;
    bit  arm_acc = 1'b0;
    time t_first_acc = 0;
    time t_usr = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] errc_for(input int n);
`ifdef XP10_DECOMP_FE_TLV_ERR_CNT_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    // Word-level routing rules applied to each accepted word
    task automatic model(input logic [63:0] d, input logic [2:0] c);
        bit sot, eot, to_usr;
        sot = c[0];
        eot = c[1];
        if (m_mode == 0 || m_mode == 3) begin
            if (sot) begin
                m_type = d[7:0];
                m_len  = int'(d[31:16]);
                m_cnt  = 1;
                to_usr = (m_type < 8'd32) && MASK[m_type[4:0]];
                if (to_usr) exp_usr.push_back({m_type, c, d});
                else        exp_pt.push_back({c, d});
                if (eot) begin
                    if (m_len != 1) m_err++;
                    m_mode = 0;
                end else begin
                    m_mode = to_usr ? 2 : 1;
                end
            end else begin
                if (m_mode == 0) m_err++;
                m_mode = 3;
            end
        end else begin
            if (sot) begin
                if (m_mode == 2) exp_usr.push_back({m_type, c | 3'b010, d});
                else             exp_pt.push_back({c | 3'b010, d});
                m_err++;
                m_mode = 0;
            end else begin
                m_cnt++;
                if (m_mode == 2) exp_usr.push_back({m_type, c, d});
                else             exp_pt.push_back({c, d});
                if (eot) begin
                    if (m_cnt != m_len) m_err++;
                    m_mode = 0;
                end
            end
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [2:0] c);
        int n;
        n = 0;
        @(negedge clk);
        axi_ib_tvalid = 1'b1;
        axi_ib_tdata  = d;
        axi_ib_tctl   = c;
        while (!axi_ib_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!axi_ib_tready) begin
            chk("tready_timeout", 128'(axi_ib_tready), 128'(1));
            axi_ib_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        if (arm_acc) begin
            t_first_acc = $time;
            arm_acc = 1'b0;
        end
        model(d, c);
    endtask

    task automatic idle();
        @(negedge clk);
        axi_ib_tvalid = 1'b0;
    endtask

    task automatic send_tlv(input logic [7:0] typ, input logic [15:0] len, input int nw, input bit with_eot);
        logic [63:0] d;
        logic [2:0]  c;
        bit          last;
        for (int i = 0; i < nw; i++) begin
            last = (i == nw - 1) && with_eot;
            if (i == 0) d = {32'($urandom()), len, 8'($urandom()), typ};
            else        d = {32'($urandom()), 32'($urandom())};
            c = {last ? 1'($urandom_range(0, 1)) : 1'b0, last, (i == 0)};
            send(d, c);
        end
    endtask

    task automatic set_knobs(input bit ur, input bit af);
        @(posedge clk);
        #1;
        usr_ready   = ur;
        pt_ib_afull = af;
    endtask

    // Random backpressure, changed just after the active edge
    task automatic knobs();
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) begin
                usr_ready   = ($urandom_range(0, 3) != 0);
                pt_ib_afull = ($urandom_range(0, 4) == 0);
            end
        end
    endtask

    task automatic edge_sample();
        forever begin
            @(posedge clk);
            edge_afull = pt_ib_afull;
        end
    endtask

    task automatic monitor();
        logic [66:0] e_p;
        logic [74:0] e_u;
        logic [74:0] hold_w;
        bit          hold_v;
        hold_v = 1'b0;
        hold_w = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (!axi_ib_tready) tready_low_seen = 1'b1;
                if (err_pulse) pulses++;
                if (pt_ib_wr) begin
                    pt_wr_cnt++;
                    chk("pt_wr_while_afull", 128'(edge_afull), 128'(0));
                    if (exp_pt.size() == 0) begin
                        chk("pt_extra_word", 128'({pt_ib_ctl, pt_ib_data}), 128'(0));
                    end else begin
                        e_p = exp_pt.pop_front();
                        chk("pt_word", 128'({pt_ib_ctl, pt_ib_data}), 128'(e_p));
                    end
                end
                if (hold_v) begin
                    chk("usr_hold", 128'({usr_valid, usr_type, usr_ctl, usr_data}), 128'({1'b1, hold_w}));
                end
                hold_v = usr_valid && !usr_ready;
                hold_w = {usr_type, usr_ctl, usr_data};
                if (usr_valid && usr_ready) begin
                    usr_cnt++;
                    if (exp_usr.size() == 0) begin
                        chk("usr_extra_word", 128'({usr_type, usr_ctl, usr_data}), 128'(0));
                    end else begin
                        e_u = exp_usr.pop_front();
                        chk("usr_word", 128'({usr_type, usr_ctl, usr_data}), 128'(e_u));
                    end
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_pt.size() != 0 || exp_usr.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_pending"}, 128'(exp_pt.size() + exp_usr.size()), 128'(0));
        repeat (4) @(negedge clk);
        chk({tag, "_err_pulses"}, 128'(pulses), 128'(m_err));
        chk({tag, "_err_cnt"}, 128'(err_cnt), 128'(errc_for(m_err)));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctl"}, 128'({axi_ib_tready, pt_ib_wr, usr_valid, err_pulse, err_cnt}), 128'(0));
        chk({tag, "_data"}, {pt_ib_data, usr_data}, 128'(0));
        chk({tag, "_misc"}, 128'({pt_ib_ctl, usr_ctl, usr_type}), 128'(0));
    endtask

    initial begin
        int n;
        int r;
        logic [7:0]  typ;
        logic [15:0] len;
        int          nw;
        axi_ib_tvalid = 1'b0;
        axi_ib_tdata  = 64'd0;
        axi_ib_tctl   = 3'd0;
        usr_ready     = 1'b0;
        pt_ib_afull   = 1'b0;
        fork
            monitor();
            knobs();
            edge_sample();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("tready_after_reset", 128'(axi_ib_tready), 128'(1));

        // Type 0x02, len 3, no backpressure: user path, +2 latency
        set_knobs(1'b1, 1'b0);
        usr_cnt = 0;
        arm_acc = 1'b1;
        fork
            begin
                send_tlv(8'h02, 16'd3, 3, 1'b1);
                idle();
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!usr_valid && n < 30);
                t_usr = $time;
            end
        join
        chk("latency_first_usr", 128'(t_usr - t_first_acc), 128'(PERIOD + PERIOD/2));
        drain("tlv02");
        chk("tlv02_usr_words", 128'(usr_cnt), 128'(3));
        chk("tlv02_err_cnt0", 128'(err_cnt), 128'(0));

        // Type 0x05, len 4, FIFO almost-full for 5 cycles mid-TLV
        pt_wr_cnt = 0;
        tready_low_seen = 1'b0;
        fork
            begin
                send_tlv(8'h05, 16'd4, 4, 1'b1);
                idle();
            end
            begin
                n = 0;
                while (pt_wr_cnt < 1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                set_knobs(1'b1, 1'b1);
                repeat (4) @(posedge clk);
                set_knobs(1'b1, 1'b0);
            end
        join
        drain("tlv05");
        chk("tlv05_pt_writes", 128'(pt_wr_cnt), 128'(4));
        chk("tlv05_tready_drop", 128'(tready_low_seen), 128'(1));

        // Orphan body word in IDLE, then type 0x03 len 2
        usr_cnt = 0;
        send({32'($urandom()), 32'($urandom())}, 3'b000);
        send_tlv(8'h03, 16'd2, 2, 1'b1);
        idle();
        drain("orphan");
        chk("orphan_usr_words", 128'(usr_cnt), 128'(2));
        chk("orphan_pulses", 128'(pulses), 128'(1));
        chk("orphan_err_cnt", 128'(err_cnt), 128'(errc_for(1)));

        // Header length 5, EOT on word 3
        usr_cnt = 0;
        send_tlv(8'h02, 16'd5, 3, 1'b1);
        idle();
        drain("short");
        chk("short_usr_words", 128'(usr_cnt), 128'(3));
        chk("short_pulses", 128'(pulses), 128'(2));
        chk("short_err_cnt", 128'(err_cnt), 128'(errc_for(2)));

        // Reset after 2nd word of a 4-word TLV
        send_tlv(8'h05, 16'd4, 2, 1'b0);
        @(negedge clk);
        axi_ib_tvalid = 1'b0;
        #1;
        rst = 1'b1;
        exp_pt.delete();
        exp_usr.delete();
        m_mode = 0;
        m_err  = 0;
        pulses = 0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        usr_cnt = 0;
        pt_wr_cnt = 0;
        send_tlv(8'h02, 16'd3, 3, 1'b1);
        send_tlv(8'h43, 16'd2, 2, 1'b1);
        idle();
        drain("post_reset");
        chk("post_reset_usr_words", 128'(usr_cnt), 128'(3));
        chk("post_reset_pt_writes", 128'(pt_wr_cnt), 128'(2));

        // Randomized traffic with random backpressure
        rnd_bp = 1'b1;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) send({32'($urandom()), 32'($urandom())}, {1'b0, 1'($urandom_range(0, 1)), 1'b0});
            case ($urandom_range(0, 5))
                0:       typ = 8'h02;
                1:       typ = 8'h03;
                2:       typ = 8'h05;
                3:       typ = 8'h00;
                4:       typ = 8'h43;
                default: typ = 8'($urandom());
            endcase
            len = 16'($urandom_range(1, 5));
            nw  = int'(len);
            if (r == 1) nw = nw + 1;
            if (r == 2 && nw > 1) nw = nw - 1;
            if (r == 4) len = 16'd0;
            send_tlv(typ, len, nw, (r != 3));
        end
        idle();
        drain("random");
        rnd_bp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_xp10_decomp_fe_tlv_split

`default_nettype wire
